// File: rtl/qupls_commit_sequencer.sv
// ROB retirement sequencer: advances the head pointer, serialises oddball and exception handshakes.
// Optional retirement/stall statistics are built when QUPLS_COMMIT_STATS_EN is defined.
module qupls_commit_sequencer #(
  parameter int ROB_ENTRIES = 16,
  parameter int MAX_CMT     = 6,
  localparam int NDX_W      = $clog2(ROB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmtcnt,
  input  logic             do_commit,
  input  logic             head_oddball,
  input  logic             head_excv,
  input  logic [NDX_W-1:0] tail_i,
  input  logic             flush_i,
  input  logic             odd_ack,
  input  logic             exc_ack,
  output logic [NDX_W-1:0] head_o,
  output logic             cmt_o,
  output logic [2:0]       cmt_cnt_o,
  output logic             odd_req,
  output logic             exc_req,
  output logic             rob_flush_o,
  output logic             busy_o,
  output logic [63:0]      stat_cmt_o,
  output logic [63:0]      stat_stall_o
);

  // Sum needs room for head plus the largest possible count, even for tiny ROBs.
  localparam int SUM_W = (NDX_W + 1 > 4) ? NDX_W + 1 : 4;

  typedef enum logic [1:0] {RUN = 2'd0, ODD = 2'd1, EXC = 2'd2} state_t;
  state_t state;

  logic [2:0] n_clamp;

  function automatic logic [NDX_W-1:0] wrap_add(input logic [NDX_W-1:0] h, input logic [2:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(h) + SUM_W'(n);
    if (s >= SUM_W'(ROB_ENTRIES))
      s = s - SUM_W'(ROB_ENTRIES);
    return s[NDX_W-1:0];
  endfunction

  assign n_clamp = (cmtcnt > 3'(MAX_CMT)) ? 3'(MAX_CMT) : cmtcnt;
  assign busy_o  = (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      head_o      <= '0;
      cmt_o       <= 1'b0;
      cmt_cnt_o   <= 3'd0;
      odd_req     <= 1'b0;
      exc_req     <= 1'b0;
      rob_flush_o <= 1'b0;
    end else begin
      cmt_o       <= 1'b0;
      cmt_cnt_o   <= 3'd0;
      rob_flush_o <= 1'b0;
      case (state)
        RUN: begin
          if (flush_i) begin
            state <= RUN;
          end else if (head_excv) begin
            exc_req <= 1'b1;
            state   <= EXC;
          end else if (do_commit && head_oddball) begin
            odd_req <= 1'b1;
            state   <= ODD;
          end else if (do_commit && n_clamp != 3'd0) begin
            head_o    <= wrap_add(head_o, n_clamp);
            cmt_o     <= 1'b1;
            cmt_cnt_o <= n_clamp;
          end
        end
        ODD: begin
          // A same-cycle flush beats the ack: the oddball is discarded, not retired.
          if (flush_i) begin
            odd_req <= 1'b0;
            state   <= RUN;
          end else if (odd_ack) begin
            head_o    <= wrap_add(head_o, 3'd1);
            cmt_o     <= 1'b1;
            cmt_cnt_o <= 3'd1;
            odd_req   <= 1'b0;
            state     <= RUN;
          end
        end
        EXC: begin
          if (flush_i) begin
            exc_req <= 1'b0;
            state   <= RUN;
          end else if (exc_ack) begin
            head_o      <= tail_i;
            rob_flush_o <= 1'b1;
            exc_req     <= 1'b0;
            state       <= RUN;
          end
        end
        default: begin
          odd_req <= 1'b0;
          exc_req <= 1'b0;
          state   <= RUN;
        end
      endcase
    end
  end

`ifdef QUPLS_COMMIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cmt_o   <= 64'd0;
      stat_stall_o <= 64'd0;
    end else begin
      if (cmt_o)
        stat_cmt_o <= stat_cmt_o + 64'(cmt_cnt_o);
      if (busy_o)
        stat_stall_o <= stat_stall_o + 64'd1;
    end
  end
`else
  assign stat_cmt_o   = 64'd0;
  assign stat_stall_o = 64'd0;
`endif

endmodule

// File: tb/tb_qupls_commit_sequencer.sv
// Self-checking bench for qupls_commit_sequencer: directed vector table, hand sequences,
// then randomized traffic against a behavioural model. Two instances: 16-entry and 12-entry ROB.
module tb_qupls_commit_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmtcnt = '0;
  logic       do_commit = 1'b0, head_oddball = 1'b0, head_excv = 1'b0;
  logic       flush_i = 1'b0, odd_ack = 1'b0, exc_ack = 1'b0;
  logic [3:0] tail_i = '0;

  logic [3:0]  head16, head12;
  logic        cmt16, cmt12, oreq16, oreq12, ereq16, ereq12, rf16, rf12, busy16, busy12;
  logic [2:0]  cnt16, cnt12;
  logic [63:0] scmt16, scmt12, sstall16, sstall12;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qupls_commit_sequencer #(.ROB_ENTRIES(16), .MAX_CMT(6)) u_dut16 (
    .clk(clk), .rst(rst), .cmtcnt(cmtcnt), .do_commit(do_commit), .head_oddball(head_oddball),
    .head_excv(head_excv), .tail_i(tail_i), .flush_i(flush_i), .odd_ack(odd_ack), .exc_ack(exc_ack),
    .head_o(head16), .cmt_o(cmt16), .cmt_cnt_o(cnt16), .odd_req(oreq16), .exc_req(ereq16),
    .rob_flush_o(rf16), .busy_o(busy16), .stat_cmt_o(scmt16), .stat_stall_o(sstall16)
  );

  qupls_commit_sequencer #(.ROB_ENTRIES(12), .MAX_CMT(6)) u_dut12 (
    .clk(clk), .rst(rst), .cmtcnt(cmtcnt), .do_commit(do_commit), .head_oddball(head_oddball),
    .head_excv(head_excv), .tail_i(tail_i), .flush_i(flush_i), .odd_ack(odd_ack), .exc_ack(exc_ack),
    .head_o(head12), .cmt_o(cmt12), .cmt_cnt_o(cnt12), .odd_req(oreq12), .exc_req(ereq12),
    .rob_flush_o(rf12), .busy_o(busy12), .stat_cmt_o(scmt12), .stat_stall_o(sstall12)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic dc, input logic [2:0] cnt, input logic odd, input logic excv,
                        input logic fl, input logic oack, input logic eack, input logic [3:0] tail);
    do_commit = dc; cmtcnt = cnt; head_oddball = odd; head_excv = excv;
    flush_i = fl; odd_ack = oack; exc_ack = eack; tail_i = tail;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors from reset: inputs applied for one cycle, outputs expected afterwards.
  typedef struct {
    logic dc; logic [2:0] cnt; logic odd; logic excv; logic fl; logic oack; logic eack; logic [3:0] tail;
    logic [3:0] h16; logic [3:0] h12; logic cmt; logic [2:0] ccnt; logic oreq; logic ereq; logic rf; logic busy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic dc, input logic [2:0] cnt, input logic odd, input logic excv,
                              input logic fl, input logic oack, input logic eack, input logic [3:0] tail,
                              input logic [3:0] h16, input logic [3:0] h12, input logic cmt,
                              input logic [2:0] ccnt, input logic oreq, input logic ereq,
                              input logic rf, input logic busy);
    vec_t v;
    v.dc = dc; v.cnt = cnt; v.odd = odd; v.excv = excv; v.fl = fl; v.oack = oack; v.eack = eack;
    v.tail = tail; v.h16 = h16; v.h12 = h12; v.cmt = cmt; v.ccnt = ccnt; v.oreq = oreq;
    v.ereq = ereq; v.rf = rf; v.busy = busy;
    return v;
  endfunction

  // Behavioural reference: mode 0=running, 1=waiting on oddball, 2=waiting on exception.
  int          m_mode;
  int          m_h16, m_h12, m_cnt;
  logic        m_cmt, m_odd, m_exc, m_rf;
  logic [63:0] m_scmt, m_sstall;

  task automatic model_reset();
    m_mode = 0; m_h16 = 0; m_h12 = 0; m_cnt = 0;
    m_cmt = 0; m_odd = 0; m_exc = 0; m_rf = 0; m_scmt = 0; m_sstall = 0;
  endtask

  task automatic model_step();
    int n;
    if (m_mode != 0) m_sstall = m_sstall + 1;
    if (m_cmt) m_scmt = m_scmt + 64'(m_cnt);
    m_cmt = 0; m_cnt = 0; m_rf = 0;
    if (m_mode == 0) begin
      if (flush_i) begin
      end else if (head_excv) begin
        m_exc = 1; m_mode = 2;
      end else if (do_commit && head_oddball) begin
        m_odd = 1; m_mode = 1;
      end else if (do_commit) begin
        n = (int'(cmtcnt) < 6) ? int'(cmtcnt) : 6;
        if (n > 0) begin
          m_h16 = (m_h16 + n) % 16; m_h12 = (m_h12 + n) % 12;
          m_cmt = 1; m_cnt = n;
        end
      end
    end else if (m_mode == 1) begin
      if (flush_i) begin
        m_odd = 0; m_mode = 0;
      end else if (odd_ack) begin
        m_h16 = (m_h16 + 1) % 16; m_h12 = (m_h12 + 1) % 12;
        m_cmt = 1; m_cnt = 1; m_odd = 0; m_mode = 0;
      end
    end else begin
      if (flush_i) begin
        m_exc = 0; m_mode = 0;
      end else if (exc_ack) begin
        m_h16 = int'(tail_i); m_h12 = int'(tail_i);
        m_rf = 1; m_exc = 0; m_mode = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] es_c, es_s;
`ifdef QUPLS_COMMIT_STATS_EN
    es_c = m_scmt; es_s = m_sstall;
`else
    es_c = 64'd0; es_s = 64'd0;
`endif
    chk("rnd_head16", 64'(head16), 64'(m_h16));
    chk("rnd_head12", 64'(head12), 64'(m_h12));
    chk("rnd_cmt16", 64'(cmt16), 64'(m_cmt));
    chk("rnd_cmt12", 64'(cmt12), 64'(m_cmt));
    chk("rnd_cnt16", 64'(cnt16), 64'(m_cnt));
    chk("rnd_cnt12", 64'(cnt12), 64'(m_cnt));
    chk("rnd_oreq", 64'({oreq16, oreq12}), 64'({m_odd, m_odd}));
    chk("rnd_ereq", 64'({ereq16, ereq12}), 64'({m_exc, m_exc}));
    chk("rnd_rflush", 64'({rf16, rf12}), 64'({m_rf, m_rf}));
    chk("rnd_busy", 64'({busy16, busy12}), 64'({m_mode != 0, m_mode != 0}));
    chk("rnd_cmt_and_flush", 64'(cmt16 & rf16), 64'd0);
    chk("rnd_stat_cmt", scmt16, es_c);
    chk("rnd_stat_cmt12", scmt12, es_c);
    chk("rnd_stat_stall", sstall16, es_s);
    chk("rnd_stat_stall12", sstall12, es_s);
  endtask

  initial begin
    logic [63:0] stall0;
    // dc cnt odd excv fl oack eack tail | h16 h12 cmt ccnt oreq ereq rf busy
    vecs[0]  = mk(1, 4, 0, 0, 0, 0, 0, 0,   4,  4, 1, 4, 0, 0, 0, 0);
    vecs[1]  = mk(1, 4, 0, 0, 0, 0, 0, 0,   8,  8, 1, 4, 0, 0, 0, 0);
    vecs[2]  = mk(1, 4, 0, 0, 0, 0, 0, 0,  12,  0, 1, 4, 0, 0, 0, 0);
    vecs[3]  = mk(1, 2, 0, 0, 0, 0, 0, 0,  14,  2, 1, 2, 0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 0, 0, 0, 0, 0, 0,   3,  7, 1, 5, 0, 0, 0, 0);
    vecs[5]  = mk(1, 7, 0, 0, 0, 0, 0, 0,   9,  1, 1, 6, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0,   9,  1, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 5, 0, 0, 0, 0, 0, 0,   9,  1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3, 0, 0, 1, 0, 0, 0,   9,  1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0,   9,  1, 0, 0, 1, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,   9,  1, 0, 0, 1, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0,   9,  1, 0, 0, 1, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 0,  10,  2, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(1, 2, 1, 1, 0, 0, 0, 0,  10,  2, 0, 0, 0, 1, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0,  10,  2, 0, 0, 0, 1, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 9,   9,  9, 0, 0, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   9,  9, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 0, 0, 0, 0, 0,   9,  9, 0, 0, 1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 1, 1, 0, 0,   9,  9, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 0, 0, 0, 0,   9,  9, 0, 0, 0, 1, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 0, 1, 3,   9,  9, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 1, 5,   9,  9, 0, 0, 0, 0, 0, 0);

    // Reset state
    cycle(); cycle();
    chk("reset_head", 64'({head16, head12}), 64'd0);
    chk("reset_outs", 64'({cmt16, cnt16, oreq16, ereq16, rf16, busy16}), 64'd0);
    chk("reset_stats", scmt16 | sstall16, 64'd0);
    @(negedge clk); rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      set_in(vecs[i].dc, vecs[i].cnt, vecs[i].odd, vecs[i].excv, vecs[i].fl,
             vecs[i].oack, vecs[i].eack, vecs[i].tail);
      cycle();
      $display("[TB] vec %0d head16=%0d head12=%0d cmt=%0d cnt=%0d odd=%0d exc=%0d rf=%0d busy=%0d",
               i, head16, head12, cmt16, cnt16, oreq16, ereq16, rf16, busy16);
      chk($sformatf("vec%0d_head16", i), 64'(head16), 64'(vecs[i].h16));
      chk($sformatf("vec%0d_head12", i), 64'(head12), 64'(vecs[i].h12));
      chk($sformatf("vec%0d_cmt", i), 64'({cmt16, cnt16}), 64'({vecs[i].cmt, vecs[i].ccnt}));
      chk($sformatf("vec%0d_reqs", i), 64'({oreq16, ereq16, rf16, busy16}),
          64'({vecs[i].oreq, vecs[i].ereq, vecs[i].rf, vecs[i].busy}));
    end

    // Oddball at head 5 held for several cycles before the ack.
    @(negedge clk); rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    set_in(1, 5, 0, 0, 0, 0, 0, 0); cycle();
    chk("odd_setup_head", 64'(head16), 64'd5);
    stall0 = sstall16;
    set_in(1, 1, 1, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("odd_hold%0d", k), 64'({oreq16, busy16, head16}), 64'({2'b11, 4'd5}));
      cycle();
    end
    chk("odd_hold4", 64'({oreq16, busy16}), 64'b11);
    set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("odd_done", 64'({head16, cmt16, cnt16, oreq16, busy16}), 64'({4'd6, 1'b1, 3'd1, 2'b00}));
`ifdef QUPLS_COMMIT_STATS_EN
    chk("odd_stall_delta", sstall16 - stall0, 64'd5);
`else
    chk("odd_stall_delta", sstall16 - stall0, 64'd0);
`endif

    // Asynchronous reset while waiting in EXC.
    set_in(0, 0, 1, 1, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("exc_enter", 64'({ereq16, busy16}), 64'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_exc", 64'({ereq16, busy16, head16, head12}), 64'd0);
    @(negedge clk); rst = 1'b0;
    cycle();
    chk("post_rst", 64'({ereq16, oreq16, head16}), 64'd0);

    // Randomized traffic against the reference model.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int r = 0; r < 1500; r++) begin
      set_in(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), ($urandom_range(0, 19) < 3),
             ($urandom_range(0, 19) < 2), ($urandom_range(0, 19) < 2), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 11)));
      model_step();
      cycle();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
